// File: rtl/traffic_pkg.sv
// Shared code enums, lamp bit positions and code-to-lamp helpers for the
// traffic lamp driver.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED     = 2'b00,
    YELLOW  = 2'b01,
    GREEN   = 2'b10,
    INVALID = 2'b11
  } light_code_t;

  typedef enum logic [1:0] {
    PED_DONT_WALK = 2'b00,
    PED_FLASH     = 2'b01,
    PED_WALK      = 2'b10,
    PED_INVALID   = 2'b11
  } ped_code_t;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'b00,
    ST_CONFIRM = 2'b01,
    ST_FAULT   = 2'b10
  } mon_state_t;

  localparam int LAMP_RED = 2;
  localparam int LAMP_YEL = 1;
  localparam int LAMP_GRN = 0;
  localparam int PED_DW   = 1;
  localparam int PED_W    = 0;

  // Invalid vehicle codes fall back to a steady red.
  function automatic logic [2:0] veh_lamp(input light_code_t code);
    logic [2:0] lamp;
    lamp = '0;
    case (code)
      YELLOW:  lamp[LAMP_YEL] = 1'b1;
      GREEN:   lamp[LAMP_GRN] = 1'b1;
      default: lamp[LAMP_RED] = 1'b1;
    endcase
    return lamp;
  endfunction

  // Invalid pedestrian codes fall back to a steady don't-walk.
  function automatic logic [1:0] ped_lamp(input ped_code_t code, input logic phase);
    logic [1:0] lamp;
    lamp = '0;
    case (code)
      PED_WALK:  lamp[PED_W]  = 1'b1;
      PED_FLASH: lamp[PED_DW] = phase;
      default:   lamp[PED_DW] = 1'b1;
    endcase
    return lamp;
  endfunction

  function automatic logic is_conflict(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] pa, input logic [1:0] pb);
    logic a_go, b_go, bad;
    a_go = (a != RED);
    b_go = (b != RED);
    bad  = (a == INVALID) || (b == INVALID) || (pa == PED_INVALID) || (pb == PED_INVALID);
    return (a_go && b_go) || bad || (a_go && pa == PED_WALK) || (b_go && pb == PED_WALK);
  endfunction

endpackage

// File: rtl/traffic_blink_gen.sv
// Free-running blink phase generator: phase toggles every BLINK_HALF cycles,
// starting lit after reset.
module traffic_blink_gen
  import traffic_pkg::*;
#(
  parameter int BLINK_HALF = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic phase
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == CW'(BLINK_HALF - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver with blink generation and latched conflict monitor.
// Optional lamp test input enabled by defining LAMP_TEST_EN.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int BLINK_HALF    = 2,
  parameter int CONFLICT_FILT = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] PA,
  input  logic [1:0] PB,
  output logic [2:0] A_LAMP,
  output logic [2:0] B_LAMP,
  output logic [1:0] PA_LAMP,
  output logic [1:0] PB_LAMP,
  output logic       FAULT
`ifdef LAMP_TEST_EN
  ,
  input  logic       LAMP_TEST
`endif
);

  localparam int FW = $clog2(CONFLICT_FILT + 1);

  logic       phase;
  logic       conflict;
  logic       lamp_test;

  mon_state_t state_q, state_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [2:0] a_lamp_q, a_lamp_d, b_lamp_q, b_lamp_d;
  logic [1:0] pa_lamp_q, pa_lamp_d, pb_lamp_q, pb_lamp_d;
  logic       fault_q, fault_d;

  traffic_blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .CLK   (CLK),
    .RST   (RST),
    .phase (phase)
  );

`ifdef LAMP_TEST_EN
  assign lamp_test = LAMP_TEST;
`else
  assign lamp_test = 1'b0;
`endif

  assign conflict = is_conflict(A, B, PA, PB);

  // Monitor: a conflict must persist CONFLICT_FILT cycles before latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (conflict) begin
          cnt_d   = FW'(1);
          state_d = (CONFLICT_FILT <= 1) ? ST_FAULT : ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        if (conflict) begin
          cnt_d = cnt_q + FW'(1);
          if (cnt_d >= FW'(CONFLICT_FILT)) state_d = ST_FAULT;
        end else begin
          cnt_d   = '0;
          state_d = ST_NORMAL;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d = ST_NORMAL;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamp patterns use the next monitor state so the fault pattern appears
  // on the same edge that latches FAULT.
  always_comb begin
    fault_d   = (state_d == ST_FAULT);
    a_lamp_d  = veh_lamp(light_code_t'(A));
    b_lamp_d  = veh_lamp(light_code_t'(B));
    pa_lamp_d = ped_lamp(ped_code_t'(PA), phase);
    pb_lamp_d = ped_lamp(ped_code_t'(PB), phase);
    if (fault_d) begin
      a_lamp_d  = {phase, 2'b00};
      b_lamp_d  = {phase, 2'b00};
      pa_lamp_d = 2'b10;
      pb_lamp_d = 2'b10;
    end
    if (lamp_test) begin
      a_lamp_d  = 3'b111;
      b_lamp_d  = 3'b111;
      pa_lamp_d = 2'b11;
      pb_lamp_d = 2'b11;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_NORMAL;
      cnt_q     <= '0;
      a_lamp_q  <= 3'b100;
      b_lamp_q  <= 3'b100;
      pa_lamp_q <= 2'b10;
      pb_lamp_q <= 2'b10;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_lamp_q  <= a_lamp_d;
      b_lamp_q  <= b_lamp_d;
      pa_lamp_q <= pa_lamp_d;
      pb_lamp_q <= pb_lamp_d;
      fault_q   <= fault_d;
    end
  end

  assign A_LAMP  = a_lamp_q;
  assign B_LAMP  = b_lamp_q;
  assign PA_LAMP = pa_lamp_q;
  assign PB_LAMP = pb_lamp_q;
  assign FAULT   = fault_q;

endmodule
